// File: rtl/spi_instr_master_if.sv
// Request/response and SPI pin bundle for spi_instr_master.
// The master modport is the initiator's view. The slave modport is the
// counterpart: the host driving requests and the SPI responder driving miso.
interface spi_instr_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic       req_hi;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;

  modport master (
    input  req_valid, req_write, req_hi, req_addr, req_wdata, miso,
    output req_ready, rsp_valid, rsp_rdata, busy, sclk, cs_n, mosi
  );

  modport slave (
    output req_valid, req_write, req_hi, req_addr, req_wdata, miso,
    input  req_ready, rsp_valid, rsp_rdata, busy, sclk, cs_n, mosi
  );
endinterface

// File: rtl/spi_instr_master.sv
// SPI mode-0 initiator issuing 16-bit {cmd, data} register-access frames.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request, cs_n high
// SETUP | cs_n low, first bit on mosi, CLK_DIV cycles before first rise
// SHIFT | 16 sclk periods, CLK_DIV high / CLK_DIV low each
// HOLD  | cs_n low, sclk low for CLK_DIV cycles after last fall
// GAP   | cs_n high for 2*CLK_DIV cycles before returning to IDLE
//
// Every output is a flop. mosi is the MSB of the frame shift register, so it
// only moves on the edge that drops sclk (or on accept, while sclk is low).
module spi_instr_master #(
  parameter int CLK_DIV = 2
) (
  input logic                clk,
  input logic                rst,
  spi_instr_master_if.master bus
);

  localparam int            CW     = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] C_HALF = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_GAP  = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_bit, w_bit_nxt;
  logic [15:0]   r_shift, w_shift_nxt;
  logic [7:0]    r_rx, w_rx_nxt;
  logic [7:0]    r_rdata, w_rdata_nxt;
  logic          r_is_read, w_is_read_nxt;
  logic          r_sclk, w_sclk_nxt;
  logic          r_cs_n, w_cs_n_nxt;
  logic          r_rsp_valid, w_rsp_valid_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_ready, w_ready_nxt;

  logic w_accept;
  logic w_cnt_zero;

  assign w_accept   = bus.req_valid & r_ready;
  assign w_cnt_zero = (r_cnt == '0);

  // State and datapath registers; reset aborts any frame and raises cs_n.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_rx        <= '0;
      r_rdata     <= '0;
      r_is_read   <= 1'b0;
      r_sclk      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_rx        <= w_rx_nxt;
      r_rdata     <= w_rdata_nxt;
      r_is_read   <= w_is_read_nxt;
      r_sclk      <= w_sclk_nxt;
      r_cs_n      <= w_cs_n_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_ready     <= w_ready_nxt;
    end
  end

  // Next-state selection; every phase ends when the down-counter hits zero.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_state_nxt = S_SETUP;
      S_SETUP: if (w_cnt_zero) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_cnt_zero && r_sclk && (r_bit == 4'd0)) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_cnt_zero) w_state_nxt = S_GAP;
      S_GAP:   if (w_cnt_zero) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, counters and shift registers.
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_bit_nxt       = r_bit;
    w_shift_nxt     = r_shift;
    w_rx_nxt        = r_rx;
    w_rdata_nxt     = r_rdata;
    w_is_read_nxt   = r_is_read;
    w_sclk_nxt      = r_sclk;
    w_cs_n_nxt      = r_cs_n;
    w_rsp_valid_nxt = 1'b0;
    w_busy_nxt      = r_busy;
    w_ready_nxt     = r_ready;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shift_nxt   = {bus.req_write, bus.req_hi, bus.req_addr,
                           bus.req_write ? bus.req_wdata : 8'h00};
          w_is_read_nxt = ~bus.req_write;
          w_rx_nxt      = '0;
          w_bit_nxt     = 4'd15;
          w_cnt_nxt     = C_HALF;
          w_cs_n_nxt    = 1'b0;
          w_sclk_nxt    = 1'b0;
          w_busy_nxt    = 1'b1;
          w_ready_nxt   = 1'b0;
        end
      end

      S_SETUP: begin
        if (w_cnt_zero) begin
          w_sclk_nxt = 1'b1;
          w_cnt_nxt  = C_HALF;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end

      S_SHIFT: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - C_ONE;
        end else begin
          w_cnt_nxt = C_HALF;
          if (r_sclk) begin
            // Falling edge: advance mosi unless this was the final bit.
            w_sclk_nxt = 1'b0;
            if (r_bit != 4'd0) begin
              w_bit_nxt   = r_bit - 4'd1;
              w_shift_nxt = {r_shift[14:0], 1'b0};
            end
          end else begin
            // Rising edge: only the data-byte miso samples are kept.
            w_sclk_nxt = 1'b1;
            if (r_bit < 4'd8) w_rx_nxt = {r_rx[6:0], bus.miso};
          end
        end
      end

      S_HOLD: begin
        if (w_cnt_zero) begin
          w_cs_n_nxt      = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_shift_nxt     = '0;
          w_cnt_nxt       = C_GAP;
          if (r_is_read) w_rdata_nxt = r_rx;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end

      S_GAP: begin
        if (w_cnt_zero) begin
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end

      default: begin
        w_cs_n_nxt  = 1'b1;
        w_sclk_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.req_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.sclk      = r_sclk;
  assign bus.cs_n      = r_cs_n;
  assign bus.mosi      = r_shift[15];

endmodule

// File: tb/tb_spi_instr_master.sv
// Bench for spi_instr_master: three instances (CLK_DIV = 2, 1, 3) driven
// one at a time, with an SPI responder/monitor and a frame-level model.
module tb_spi_instr_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       tb_valid [3];
  logic       tb_write [3];
  logic       tb_hi    [3];
  logic [5:0] tb_addr  [3];
  logic [7:0] tb_wdata [3];
  logic       tb_miso  [3];

  logic       ob_ready [3];
  logic       ob_rspv  [3];
  logic       ob_busy  [3];
  logic       ob_sclk  [3];
  logic       ob_cs_n  [3];
  logic       ob_mosi  [3];
  logic [7:0] ob_rdata [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DV = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    spi_instr_master_if u_if ();
    spi_instr_master #(.CLK_DIV(DV)) u_dut (.clk(clk), .rst(rst), .bus(u_if));
    assign u_if.req_valid = tb_valid[g];
    assign u_if.req_write = tb_write[g];
    assign u_if.req_hi    = tb_hi[g];
    assign u_if.req_addr  = tb_addr[g];
    assign u_if.req_wdata = tb_wdata[g];
    assign u_if.miso      = tb_miso[g];
    assign ob_ready[g] = u_if.req_ready;
    assign ob_rspv[g]  = u_if.rsp_valid;
    assign ob_busy[g]  = u_if.busy;
    assign ob_sclk[g]  = u_if.sclk;
    assign ob_cs_n[g]  = u_if.cs_n;
    assign ob_mosi[g]  = u_if.mosi;
    assign ob_rdata[g] = u_if.rsp_rdata;
  end

  // Responder/monitor state, written only by the monitor process.
  int          rises [3];
  int          cs_low [3];
  int          hi_run [3];
  int          gap [3];
  int          idle_err [3];
  int          mosi_err [3];
  int          rsp_cnt [3];
  logic [15:0] bits [3];
  logic        prev_cs [3];
  logic        prev_sclk [3];
  logic        prev_mosi [3];

  // Written only by the stimulus process.
  logic [7:0] resp_b [3];
  logic [7:0] junk_b [3];
  logic [7:0] model_rdata [3];
  logic       nxt_w, nxt_hi;
  logic [5:0] nxt_a;
  logic [7:0] nxt_wd;
  int         cur;

  int tests  = 0;
  int failed = 0;

  // Responder drives miso while sclk is low (junk during the command byte,
  // the response byte during the data byte) and records what it sees.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int          r, cl, hr;
      logic [15:0] b;
      if (rst) begin
        rises[i] <= 0; bits[i] <= '0; cs_low[i] <= 0; hi_run[i] <= 0; gap[i] <= 0;
        idle_err[i] <= 0; mosi_err[i] <= 0; rsp_cnt[i] <= 0;
        prev_cs[i] <= 1'b1; prev_sclk[i] <= 1'b0; prev_mosi[i] <= 1'b0; tb_miso[i] <= 1'b0;
      end else begin
        r = rises[i]; b = bits[i]; cl = cs_low[i]; hr = hi_run[i];
        if (!ob_cs_n[i] && prev_cs[i]) begin
          gap[i] <= hr;
          r = 0; b = '0; cl = 0; hr = 0;
        end
        if (ob_cs_n[i]) hr++; else cl++;
        if (ob_sclk[i] && !prev_sclk[i]) begin
          r++;
          b = {b[14:0], ob_mosi[i]};
        end
        if (ob_sclk[i] && ob_cs_n[i]) idle_err[i] <= idle_err[i] + 1;
        if (ob_sclk[i] && prev_sclk[i] && (ob_mosi[i] !== prev_mosi[i])) mosi_err[i] <= mosi_err[i] + 1;
        if (ob_rspv[i] === 1'b1) rsp_cnt[i] <= rsp_cnt[i] + 1;
        if (!ob_cs_n[i] && !ob_sclk[i])
          tb_miso[i] <= (r < 8) ? junk_b[i][7-r] : ((r < 16) ? resp_b[i][15-r] : 1'b0);
        rises[i] <= r; bits[i] <= b; cs_low[i] <= cl; hi_run[i] <= hr;
        prev_cs[i] <= ob_cs_n[i]; prev_sclk[i] <= ob_sclk[i]; prev_mosi[i] <= ob_mosi[i];
      end
    end
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 3);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s (inst %0d): observed 0x%0h, expected 0x%0h", tag, cur, obs, exp);
    end
  endtask

  task automatic wait_ready(input int idx);
    int n = 0;
    while (ob_ready[idx] !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("ready_wait", ob_ready[idx], 1'b1);
  endtask

  // One complete frame checked against the frame-level model. When
  // 'presented' is set the request is already on the port; when 'keep' is
  // set req_valid stays high and carries the nxt_* request during the frame.
  task automatic frame(input int idx, input bit w, input bit hi, input logic [5:0] a,
                       input logic [7:0] wd, input logic [7:0] resp,
                       input bit presented, input bit keep);
    int          d, cyc, rc0;
    logic [15:0] exp_frame;
    logic [7:0]  exp_rdata;
    cur       = idx;
    d         = div_of(idx);
    exp_frame = {w, hi, a, (w ? wd : 8'h00)};
    exp_rdata = w ? model_rdata[idx] : resp;
    resp_b[idx] = resp;
    junk_b[idx] = 8'($urandom);
    if (!presented) begin
      wait_ready(idx);
      tb_write[idx] = w; tb_hi[idx] = hi; tb_addr[idx] = a; tb_wdata[idx] = wd;
      tb_valid[idx] = 1'b1;
    end
    step();
    cyc = 1;
    rc0 = rsp_cnt[idx];
    chk("t1_cs_n", ob_cs_n[idx], 1'b0);
    chk("t1_mosi", ob_mosi[idx], exp_frame[15]);
    chk("t1_busy", ob_busy[idx], 1'b1);
    chk("t1_ready", ob_ready[idx], 1'b0);
    if (keep) begin
      tb_write[idx] = nxt_w; tb_hi[idx] = nxt_hi; tb_addr[idx] = nxt_a; tb_wdata[idx] = nxt_wd;
    end else begin
      tb_valid[idx] = 1'b0;
      tb_write[idx] = 1'($urandom); tb_hi[idx] = 1'($urandom);
      tb_addr[idx] = 6'($urandom); tb_wdata[idx] = 8'($urandom);
    end
    while (ob_rspv[idx] !== 1'b1 && cyc < 40 * d + 10) begin
      step();
      cyc++;
    end
    chk("rsp_time", cyc, 1 + 33 * d);
    chk("rsp_cs_n", ob_cs_n[idx], 1'b1);
    chk("rsp_busy", ob_busy[idx], 1'b1);
    chk("rsp_rdata", ob_rdata[idx], exp_rdata);
    chk("sclk_rises", rises[idx], 16);
    chk("mosi_frame", bits[idx], exp_frame);
    chk("cs_low_cycles", cs_low[idx], 33 * d);
    chk("mosi_stable_sclk_high", mosi_err[idx], 0);
    model_rdata[idx] = exp_rdata;
    while (ob_ready[idx] !== 1'b1 && cyc < 40 * d + 10) begin
      step();
      cyc++;
    end
    chk("ready_time", cyc, 1 + 35 * d);
    chk("end_busy", ob_busy[idx], 1'b0);
    chk("rsp_pulses", rsp_cnt[idx] - rc0, 1);
  endtask

  initial begin
    int         seen, cs_bad, n, idx;
    logic [7:0] rb;
    for (int i = 0; i < 3; i++) begin
      tb_valid[i] = 1'b0; tb_write[i] = 1'b0; tb_hi[i] = 1'b0;
      tb_addr[i] = '0; tb_wdata[i] = '0;
      resp_b[i] = '0; junk_b[i] = '0; model_rdata[i] = '0;
    end
    cur = 0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 3; i++) begin
      cur = i;
      chk("rst_ready", ob_ready[i], 1'b1);
      chk("rst_busy", ob_busy[i], 1'b0);
      chk("rst_rsp_valid", ob_rspv[i], 1'b0);
      chk("rst_rdata", ob_rdata[i], 8'h00);
      chk("rst_sclk", ob_sclk[i], 1'b0);
      chk("rst_cs_n", ob_cs_n[i], 1'b1);
      chk("rst_mosi", ob_mosi[i], 1'b0);
    end

    // Directed frames at CLK_DIV = 2.
    frame(0, 1'b1, 1'b1, 6'h0F, 8'hAA, 8'($urandom), 1'b0, 1'b0);
    frame(0, 1'b0, 1'b1, 6'h2A, 8'($urandom), 8'hCC, 1'b0, 1'b0);
    frame(0, 1'b1, 1'b0, 6'h3F, 8'h55, 8'($urandom), 1'b0, 1'b0);

    // Cycle-accurate framing at CLK_DIV = 1 and 3.
    frame(1, 1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    frame(2, 1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cur = i;
      chk("sclk_idle_low", idle_err[i], 0);
    end

    // Back-to-back with req_valid held through the first frame.
    nxt_w = 1'($urandom); nxt_hi = 1'($urandom); nxt_a = 6'($urandom); nxt_wd = 8'($urandom);
    frame(0, 1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    frame(0, nxt_w, nxt_hi, nxt_a, nxt_wd, 8'($urandom), 1'b1, 1'b0);
    cur = 0;
    chk("b2b_cs_high_gap", gap[0], 2 * 2 + 1);

    // Random frames across all three dividers.
    for (int k = 0; k < 8; k++) begin
      idx = int'($urandom_range(0, 2));
      frame(idx, 1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    end

    // Reset in the middle of a read: leave a nonzero rsp_rdata first.
    rb = 8'($urandom_range(1, 255));
    frame(0, 1'b0, 1'($urandom), 6'($urandom), 8'($urandom), rb, 1'b0, 1'b0);
    cur = 0;
    wait_ready(0);
    resp_b[0] = 8'($urandom);
    junk_b[0] = 8'($urandom);
    tb_write[0] = 1'b0; tb_hi[0] = 1'b1; tb_addr[0] = 6'($urandom); tb_valid[0] = 1'b1;
    step();
    tb_valid[0] = 1'b0;
    n = 0;
    while (rises[0] != 10 && n < 200) begin
      step();
      n++;
    end
    chk("abort_reached_bit9", rises[0], 10);
    chk("abort_sclk_before", ob_sclk[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_cs_n", ob_cs_n[0], 1'b1);
    chk("abort_sclk", ob_sclk[0], 1'b0);
    chk("abort_rdata", ob_rdata[0], 8'h00);
    chk("abort_ready", ob_ready[0], 1'b1);
    for (int i = 0; i < 3; i++) model_rdata[i] = 8'h00;
    seen = 0;
    cs_bad = 0;
    repeat (4) begin
      step();
      if (ob_rspv[0] !== 1'b0) seen++;
    end
    rst = 1'b0;
    repeat (80) begin
      step();
      if (ob_rspv[0] !== 1'b0) seen++;
      if (ob_cs_n[0] !== 1'b1) cs_bad++;
    end
    chk("abort_no_rsp", seen, 0);
    chk("abort_cs_stays_high", cs_bad, 0);

    frame(0, 1'b0, 1'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    frame(0, 1'b1, 1'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/spi_instr_master.md
# spi_instr_master

Host-side SPI initiator that issues register-access frames to the instruction decoder. It accepts one register request at a time on a valid/ready port and serializes it as a 16-bit SPI mode-0 frame: a command byte followed by a data byte. For read requests it captures the responder's data byte from `miso` and returns it with a one-cycle response strobe. The block sits between the host/test controller and the PWM generator's SPI slave port.

## Interface
- `CLK_DIV`, default 2: `clk` cycles per `sclk` half-period; legal range ≥1.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; the request is accepted on `req_valid & req_ready`.
- `req_write`  in  1  1 = write, 0 = read; becomes command bit 7.
- `req_hi`  in  1  hi/lo flag; becomes command bit 6.
- `req_addr`  in  6  register address; becomes command bits 5:0.
- `req_wdata`  in  8  write data; sent as the data byte on writes.
- `rsp_valid`  out  1  one-cycle pulse at frame end (reads and writes).
- `rsp_rdata`  out  8  captured read byte; updated only by read frames, otherwise holds.
- `busy`  out  1  high from the cycle after accept until `req_ready` reasserts.
- `sclk`  out  1  SPI clock, idles low.
- `cs_n`  out  1  chip select, active low.
- `mosi`  out  1  serial data out, MSB first.
- `miso`  in  1  serial data in.

## Operation
- At accept, latch `{req_write, req_hi, req_addr}` as the command byte.
  - Latch `req_wdata` on writes; latch 0x00 on reads.
  - Input changes after accept are ignored.
- Frame shift register: 16 bits = {cmd, data}, shifted MSB first on `mosi`.
- Mode 0 timing:
  - `mosi` changes only while `sclk` is low.
  - The responder samples `mosi` on rising `sclk`.
  - The master samples `miso` on the `clk` edge that drives `sclk` high.
- Read capture: `miso` samples taken during frame bits 7..0 (the second byte) form `rsp_rdata[7:0]`, MSB first. Command-byte `miso` samples are discarded.
- FSM states and transitions:
  - IDLE: `req_ready`=1, `cs_n`=1. Goes to SETUP on accept.
  - SETUP: `cs_n`=0, `sclk`=0, `mosi`=bit 15. Lasts `CLK_DIV` cycles, then goes to SHIFT.
  - SHIFT: 16 `sclk` periods, each `CLK_DIV` cycles high then `CLK_DIV` cycles low. On each falling edge except the last, `mosi` advances to the next bit. A 4-bit counter runs 15..0. Goes to HOLD after the 16th falling edge.
  - HOLD: `cs_n`=0, `sclk`=0 for `CLK_DIV` cycles, then `cs_n`=1, `rsp_valid`=1 for one cycle, and goes to GAP.
  - GAP: `cs_n`=1 for 2·`CLK_DIV` cycles, then goes to IDLE.
- `req_valid` outside IDLE is not accepted; the requester holds it until `req_ready`.
- Reset values: `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_rdata`=0x00, `sclk`=0, `cs_n`=1, `mosi`=0. FSM goes to IDLE and both counters clear.
- Reset mid-frame:
  - Immediate abort; `cs_n` goes high asynchronously.
  - No `rsp_valid` for the aborted frame.
  - `rsp_rdata` is cleared.
- Back-to-back: a request held valid through GAP is accepted in the first IDLE cycle. Guaranteed minimum `cs_n`-high time is 2·`CLK_DIV` + 1 cycles.

## Timing
With D = `CLK_DIV` and the accept edge at T:
- T+1: `cs_n`=0, `mosi`=cmd[7], `busy`=1, `req_ready`=0.
- Rising `sclk` for bit k (k=0 is the first bit) at T+1+D+2kD.
- Falling `sclk` for bit k at T+1+2D+2kD.
- Last falling edge at T+1+32D.
- `cs_n`=1 and `rsp_valid`=1 at T+1+33D; `rsp_rdata` is valid in the same cycle.
- `req_ready`=1 and `busy`=0 at T+1+35D.
- Per-frame latency, accept to next accept, is 35D+1 cycles. With D=2: `cs_n` high at T+67, ready at T+71.
- All outputs are registered; no combinational path from `miso` or `req_*` to any output.

## Test plan
- Write, D=2: write=1, hi=1, addr=0x0F, wdata=0xAA -> `mosi` serializes 0xCF then 0xAA on rising `sclk`; `rsp_valid` at T+67; `rsp_rdata` unchanged (0x00).
- Read: write=0, hi=1, addr=0x2A; slave model drives 0xCC during byte 2 -> `mosi` = 0x6A then 0x00; `rsp_rdata`=0xCC with `rsp_valid`.
- Lo-flag write: write=1, hi=0, addr=0x3F, wdata=0x55 -> `mosi` = 0xBF then 0x55; exactly 16 rising `sclk` edges while `cs_n`=0.
- Cycle check, D=1 and D=3:
  - D=1: `cs_n` low for 33 cycles; ready at T+36.
  - D=3: `cs_n` low for 99 cycles; ready at T+106.
  - Both: `sclk` idles low outside frames.
- Back-to-back: two requests with `req_valid` held -> second accepted the first cycle `req_ready`=1; `cs_n` high for ≥2D+1 cycles between frames; the second frame uses the second request's fields.
- Reset mid-frame: assert `rst` at bit 9 of a read -> `cs_n`=1 and `sclk`=0 immediately; no `rsp_valid`; `rsp_rdata`=0x00. After release, a new request completes normally.
